// File: rtl/tetris_input_pkg.sv
// Shared constants for the NES input path: button codes, queue command encoding, DAS defaults.
// Read by input_command_queue, which builds auto-repeat only when INPUT_DAS_EN is defined.
package tetris_input_pkg;

   localparam logic [3:0] BtnNone   = 4'd0;
   localparam logic [3:0] BtnA      = 4'd1;
   localparam logic [3:0] BtnB      = 4'd2;
   localparam logic [3:0] BtnSelect = 4'd3;
   localparam logic [3:0] BtnStart  = 4'd4;
   localparam logic [3:0] BtnUp     = 4'd5;
   localparam logic [3:0] BtnDown   = 4'd6;
   localparam logic [3:0] BtnLeft   = 4'd7;
   localparam logic [3:0] BtnRight  = 4'd8;

   typedef enum logic [2:0] {
      CmdMoveL    = 3'd0,
      CmdMoveR    = 3'd1,
      CmdSoftDrop = 3'd2,
      CmdHardDrop = 3'd3,
      CmdRotCw    = 3'd4,
      CmdRotCcw   = 3'd5,
      CmdPause    = 3'd6,
      CmdSwap     = 3'd7
   } cmd_e;

   localparam int unsigned DasDelayDefault = 16;
   localparam int unsigned DasRateDefault  = 6;

   function automatic logic is_legal_code(input logic [3:0] code);
      return (code != BtnNone) && (code <= BtnRight);
   endfunction

   function automatic cmd_e map_button(input logic [3:0] code);
      case (code)
         BtnLeft:   return CmdMoveL;
         BtnRight:  return CmdMoveR;
         BtnDown:   return CmdSoftDrop;
         BtnUp:     return CmdHardDrop;
         BtnA:      return CmdRotCw;
         BtnB:      return CmdRotCcw;
         BtnStart:  return CmdPause;
         BtnSelect: return CmdSwap;
         default:   return CmdMoveL;
      endcase
   endfunction

   function automatic logic is_repeatable(input cmd_e c);
      return (c == CmdMoveL) || (c == CmdMoveR) || (c == CmdSoftDrop);
   endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Power-of-two circular command FIFO; a pop frees a slot for a push in the same cycle.
// Reads return zero while empty so the head bus is quiet when nothing is queued.
module cmd_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 3,
   localparam int unsigned PtrW = $clog2(DEPTH),
   localparam int unsigned CntW = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [CntW-1:0]  count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]  count_q;
   logic             do_push, do_pop;

   assign empty   = (count_q == '0);
   assign full    = (count_q == CntW'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign count   = count_q;
   assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
            wr_ptr_q        <= wr_ptr_q + PtrW'(1);
         end
         if (do_pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
         if (do_push && !do_pop)      count_q <= count_q + CntW'(1);
         else if (do_pop && !do_push) count_q <= count_q - CntW'(1);
      end
   end

endmodule

// File: rtl/input_command_queue.sv
// Per-frame button sampling, press/hold detection and command queueing for the grid controller.
// Define INPUT_DAS_EN to build delayed auto-shift repeats for held move/soft-drop buttons.
module input_command_queue
   import tetris_input_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned DAS_DELAY  = DasDelayDefault,
   parameter int unsigned DAS_RATE   = DasRateDefault
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic [3:0]                  button_code,
   input  logic                        frame_tick,
   output logic                        cmd_valid,
   output logic [2:0]                  cmd,
   input  logic                        cmd_ready,
   output logic [$clog2(FIFO_DEPTH):0] cmd_count,
   output logic                        overflow
);

   if (!((FIFO_DEPTH >= 2) && ((FIFO_DEPTH & (FIFO_DEPTH - 1)) == 0) && (DAS_DELAY > 0) &&
         (DAS_RATE > 0) && (DAS_DELAY + DAS_RATE <= 63))) begin : g_param_check
      $error("input_command_queue: illegal parameter set");
   end

   logic [3:0] frame_code_q, prev_code_q;
   logic       code_legal, press, push, pop, full, empty, overflow_q, repeat_push;
   cmd_e       frame_cmd;

   assign code_legal = is_legal_code(button_code);
   assign frame_cmd  = map_button(frame_code_q);
   assign press      = frame_tick && (frame_code_q != BtnNone) && (frame_code_q != prev_code_q);
   assign push       = press || repeat_push;
   assign pop        = cmd_valid && cmd_ready;
   assign cmd_valid  = !empty;
   assign overflow   = overflow_q;

   // A code seen in the tick cycle seeds the next frame rather than the one being closed.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         frame_code_q <= BtnNone;
         prev_code_q  <= BtnNone;
      end else if (frame_tick) begin
         prev_code_q  <= frame_code_q;
         frame_code_q <= code_legal ? button_code : BtnNone;
      end else if (code_legal) begin
         frame_code_q <= button_code;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) overflow_q <= 1'b0;
      else if (push && full && !pop) overflow_q <= 1'b1;
   end

`ifdef INPUT_DAS_EN
   logic [5:0] hold_cnt_q, hold_cnt_d, hold_inc;
   logic       held;

   assign held     = frame_tick && (frame_code_q != BtnNone) && (frame_code_q == prev_code_q);
   assign hold_inc = (hold_cnt_q == 6'd63) ? hold_cnt_q : hold_cnt_q + 6'd1;

   // After the first repeat the counter rewinds to DAS_DELAY so the rate period recurs forever.
   always_comb begin
      hold_cnt_d  = hold_cnt_q;
      repeat_push = 1'b0;
      if (held) begin
         hold_cnt_d = hold_inc;
         if (is_repeatable(frame_cmd)) begin
            if (hold_inc == 6'(DAS_DELAY)) begin
               repeat_push = 1'b1;
            end else if (hold_inc == 6'(DAS_DELAY + DAS_RATE)) begin
               repeat_push = 1'b1;
               hold_cnt_d  = 6'(DAS_DELAY);
            end
         end
      end else if (frame_tick) begin
         hold_cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) hold_cnt_q <= '0;
      else        hold_cnt_q <= hold_cnt_d;
   end
`else
   assign repeat_push = 1'b0;
`endif

   cmd_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (3)
   ) u_cmd_fifo (
      .clk   (clk),
      .rst_n (reset),
      .push  (push),
      .wdata (frame_cmd),
      .pop   (pop),
      .rdata (cmd),
      .full  (full),
      .empty (empty),
      .count (cmd_count)
   );

endmodule

// File: doc/input_command_queue.md
INPUT_COMMAND_QUEUE -- requirements
Module: input_command_queue

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, command queue entries, power of two, at least 2.
REQ-002 Parameter DAS_DELAY, default 16, frames a button is held before the first auto-repeat.
REQ-003 Parameter DAS_RATE, default 6, frames between later auto-repeats.
REQ-004 clk  in  1  50 MHz system clock.
REQ-005 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-006 button_code  in  4  decoded NES button: 0 none, 1 A, 2 B, 3 SELECT, 4 START, 5 UP, 6 DOWN, 7 LEFT, 8 RIGHT.
REQ-007 frame_tick  in  1  one-cycle pulse, once per 60 Hz frame.
REQ-008 cmd_valid  out  1  queue head is valid.
REQ-009 cmd  out  3  head command.
REQ-010 cmd_ready  in  1  grid controller accepts the head this cycle.
REQ-011 cmd_count  out  $clog2(FIFO_DEPTH)+1  current occupancy.
REQ-012 overflow  out  1  sticky flag, set when a command is dropped.

Function
REQ-013 Command map SHALL be: LEFT->MOVE_L 0, RIGHT->MOVE_R 1, DOWN->SOFT_DROP 2, UP->HARD_DROP 3, A->ROT_CW 4, B->ROT_CCW 5, START->PAUSE 6, SELECT->SWAP 7.
REQ-014 The frame_code register SHALL capture every nonzero legal button_code (1-8) on cycles without frame_tick; the last one in the frame wins.
REQ-015 Codes 9-15 SHALL be ignored everywhere.
REQ-016 A button_code present in the same cycle as frame_tick SHALL count toward the next frame.
REQ-017 On frame_tick, frame_code SHALL be evaluated against prev_code, then prev_code takes frame_code and frame_code clears to 0.
REQ-018 Press event: frame_code nonzero and different from prev_code -> push mapped command, hold counter cleared to 0.
REQ-019 Held event: frame_code nonzero and equal to prev_code -> handled only as REQ-026; no push otherwise.
REQ-020 Release: frame_code 0 -> no push, hold counter cleared.
REQ-021 Push latency SHALL be: entry written on the clock edge ending the frame_tick cycle; cmd_valid high in the next cycle.
REQ-022 Handshake: an entry pops on any cycle with cmd_valid and cmd_ready both high; cmd holds steady while cmd_valid is high and cmd_ready is low.
REQ-023 When full with no pop that cycle, the push SHALL be dropped, contents unchanged, overflow set.
REQ-024 When full with a pop in the same cycle, the push SHALL be accepted and cmd_count stays at FIFO_DEPTH.
REQ-025 When empty, cmd_valid SHALL be 0 and cmd SHALL be 0; read/write pointers wrap modulo FIFO_DEPTH.

Configuration
REQ-026 With INPUT_DAS_EN defined, for held MOVE_L, MOVE_R and SOFT_DROP:
  - a 6-bit hold counter increments per held frame, saturating at 63;
  - the first repeat push occurs when the counter reaches DAS_DELAY;
  - later repeats occur every DAS_RATE frames.
REQ-027 Rotation, HARD_DROP, PAUSE and SWAP SHALL never auto-repeat.
REQ-028 Without INPUT_DAS_EN, the hold counter logic SHALL be absent and held buttons SHALL produce no pushes.

Reset
REQ-029 Reset assertion SHALL immediately clear pointers, cmd_count, frame_code, prev_code, hold counter and overflow; cmd_valid=0, cmd=0.
REQ-030 A frame_tick during reset SHALL be ignored.
REQ-031 Reset asserted mid-frame SHALL discard the partial frame; the first frame_tick after release evaluates only codes captured after release.

Structure
REQ-032 Package tetris_input_pkg SHALL hold the button code constants, the command enum (3 bits) and the DAS defaults.
REQ-033 The queue SHALL be sub-module cmd_fifo, parameterised by depth and width, providing push/pop/full/empty/count.

Verification
REQ-034 Press LEFT (code 7) for one frame -> exactly one cmd=0, cmd_valid the cycle after frame_tick.
REQ-035 INPUT_DAS_EN, RIGHT held 30 frames, cmd_ready=1 -> pushes at frames 1, 17, 23, 29 (4 total); same stimulus without macro -> 1 push.
REQ-036 cmd_ready=0, five distinct presses, depth 4 -> count=4, overflow=1, queue holds first four commands in order.
REQ-037 Full queue, push and pop in the same cycle -> count stays 4, new command at tail, popped head correct.
REQ-038 Code 12, then A within one frame -> only cmd=4 pushed.
REQ-039 Reset asserted with 3 entries and a held DOWN -> cmd_valid=0, count=0 immediately; after release, DOWN held -> treated as a new press.
